// File: rtl/sys_rmw_pkg.sv
// Shared types and constants for the sys_rmw_gen read-modify-write exerciser.
// The enum encoding is also exported on the top-level state_o debug port.
package sys_rmw_pkg;

  typedef enum logic [2:0] {
    ST_SEED = 3'd0,
    ST_GEN  = 3'd1,
    ST_RD   = 3'd2,
    ST_CALC = 3'd3,
    ST_WR   = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED_DFLT = 64'h1;

  // An all-zero state would lock the LFSR, so it is replaced by SEED_DFLT.
  function automatic logic [63:0] seed_or_default(input logic [63:0] seed);
    return (seed == 64'h0) ? SEED_DFLT : seed;
  endfunction

endpackage

// File: rtl/lfsr64_galois.sv
// Combinational next-state function of the 64-bit right-shifting Galois LFSR
// (x^64+x^63+x^61+x^60+1, feedback taken from bit 0).
module lfsr64_galois
  import sys_rmw_pkg::*;
(
  input  logic [63:0] state_i,
  output logic [63:0] next_o
);

  assign next_o = (state_i >> 1) ^ (state_i[0] ? LFSR_TAPS : 64'h0);

endmodule

// File: rtl/sys_rmw_gen.sv
// Self-running read-modify-write memory exerciser on a single-outstanding req/wr/rdy bus.
// Optional feature macro OP_COUNT_EN adds op_count, a wrapping count of completed writes.
module sys_rmw_gen
  import sys_rmw_pkg::*;
#(
  parameter int          DATA_W = 64,
  parameter int          ADDR_W = 64,
  parameter int unsigned INCR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              req,
  output logic              wr,
  input  logic              rdy,
  input  logic [15:0]       seed0,
  input  logic [15:0]       seed1,
  input  logic [15:0]       seed2,
  input  logic [15:0]       seed3,
  input  logic [ADDR_W-1:0] range,
`ifdef OP_COUNT_EN
  output logic [31:0]       op_count,
`endif
  output logic [2:0]        state_o
);

  // Bus handshake: req rises with addr/wr/dout already valid and all four stay
  // frozen until the slave's one-cycle rdy pulse is sampled; req then drops and
  // stays low for at least one full cycle before the next request.

  state_t            state_q;
  logic [63:0]       lfsr_q;
  logic [63:0]       lfsr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] dout_q;
  logic              req_q;
  logic              wr_q;
  logic [63:0]       seed_cat;
`ifdef OP_COUNT_EN
  logic [31:0]       op_count_q;
`endif

  assign seed_cat = {seed3, seed2, seed1, seed0};

  lfsr64_galois u_lfsr (
    .state_i (lfsr_q),
    .next_o  (lfsr_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SEED;
      lfsr_q     <= 64'h0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= '0;
      req_q      <= 1'b0;
      wr_q       <= 1'b0;
`ifdef OP_COUNT_EN
      op_count_q <= 32'h0;
`endif
    end else begin
      case (state_q)
        ST_SEED: begin
          lfsr_q  <= seed_or_default(seed_cat);
          state_q <= ST_GEN;
        end
        // The LFSR advances here only, so exactly once per read/write pair.
        ST_GEN: begin
          lfsr_q  <= lfsr_d;
          addr_q  <= lfsr_d[ADDR_W-1:0] & range;
          req_q   <= 1'b1;
          wr_q    <= 1'b0;
          state_q <= ST_RD;
        end
        ST_RD: begin
          if (rdy) begin
            data_q  <= din;
            req_q   <= 1'b0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          dout_q  <= data_q + DATA_W'(INCR);
          req_q   <= 1'b1;
          wr_q    <= 1'b1;
          state_q <= ST_WR;
        end
        ST_WR: begin
          if (rdy) begin
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            state_q    <= ST_GAP;
`ifdef OP_COUNT_EN
            op_count_q <= op_count_q + 32'd1;
`endif
          end
        end
        ST_GAP: begin
          state_q <= ST_GEN;
        end
        default: begin
          req_q   <= 1'b0;
          wr_q    <= 1'b0;
          state_q <= ST_SEED;
        end
      endcase
    end
  end

  assign addr    = addr_q;
  assign dout    = dout_q;
  assign req     = req_q;
  assign wr      = wr_q;
  assign state_o = state_q;
`ifdef OP_COUNT_EN
  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_sys_rmw_gen.sv
// Self-checking bench for sys_rmw_gen: a bench-side slave serves each read/write,
// an independent LFSR model predicts addresses, and queues hold expected write-backs.
module tb_sys_rmw_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr;
  logic [63:0] din;
  logic [63:0] dout;
  logic        req;
  logic        wr;
  logic        rdy;
  logic [15:0] seed0, seed1, seed2, seed3;
  logic [63:0] range_v;
  logic [2:0]  state;
`ifdef OP_COUNT_EN
  logic [31:0] op_count;
`endif

  sys_rmw_gen #(.DATA_W(64), .ADDR_W(64), .INCR(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .req      (req),
    .wr       (wr),
    .rdy      (rdy),
    .seed0    (seed0),
    .seed1    (seed1),
    .seed2    (seed2),
    .seed3    (seed3),
    .range    (range_v),
`ifdef OP_COUNT_EN
    .op_count (op_count),
`endif
    .state_o  (state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycles   = 0;
  int unsigned wr_count = 0;
  logic [63:0] exp_q[$];
  logic [63:0] addr_q[$];
  logic [63:0] mem[8192];
  logic [63:0] model_lfsr;

  always @(posedge clk) cycles <= cycles + 1;

  typedef struct {
    logic [63:0] rd_data;
    logic [63:0] exp_dout;
    int          lat;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    logic [63:0] n;
    n = {1'b0, s[63:1]};
    if (s[0]) begin
      n[63] = ~n[63];
      n[62] = ~n[62];
      n[60] = ~n[60];
      n[59] = ~n[59];
    end
    return n;
  endfunction

  function automatic logic [63:0] seed_model();
    logic [63:0] s;
    s = {seed3, seed2, seed1, seed0};
    return (s == 64'h0) ? 64'h1 : s;
  endfunction

  // Driver tasks
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("req_timeout", {63'h0, req}, 64'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", {63'h0, req}, 64'h0);
    check("rst_wr", {63'h0, wr}, 64'h0);
    check("rst_addr", addr, 64'h0);
    check("rst_dout", dout, 64'h0);
`ifdef OP_COUNT_EN
    check("rst_op_count", {32'h0, op_count}, 64'h0);
`endif
    exp_q.delete();
    addr_q.delete();
    wr_count   = 0;
    model_lfsr = seed_model();
    rst = 1'b0;
  endtask

  task automatic do_read(input int lat, input bit use_mem, input logic [63:0] rd_val,
                         input logic [63:0] exp_w);
    bit          ok;
    logic [63:0] a, d, ea;
    wait_req(ok);
    if (!ok) return;
    model_lfsr = lfsr_step(model_lfsr);
    ea = model_lfsr & range_v;
    check("rd_wr", {63'h0, wr}, 64'h0);
    check("rd_addr", addr, ea);
    check("rd_in_range", addr & ~range_v, 64'h0);
    a = addr;
    d = use_mem ? mem[a[12:0]] : rd_val;
    exp_q.push_back(use_mem ? d + 64'd1 : exp_w);
    addr_q.push_back(a);
    repeat (lat) @(negedge clk);
    check("rd_addr_stable", addr, a);
    check("rd_req_held", {63'h0, req}, 64'h1);
    rdy = 1'b1;
    din = d;
    @(negedge clk);
    rdy = 1'b0;
    din = {$urandom, $urandom};
    check("rd_req_drop", {63'h0, req}, 64'h0);
    @(negedge clk);
    check("rd_to_wr_one_gap", {63'h0, req}, 64'h1);
  endtask

  task automatic do_write(input int lat, input bit use_mem, input bit abort);
    bit          ok;
    logic [63:0] a, ed;
    wait_req(ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      check("wr_unexpected", {63'h0, req}, 64'h0);
      return;
    end
    a  = addr_q.pop_front();
    ed = exp_q.pop_front();
    check("wr_wr", {63'h0, wr}, 64'h1);
    check("wr_addr", addr, a);
    check("wr_data", dout, ed);
    if (abort) begin
      #2 rst = 1'b1;
      #1 check("rst_async_req_drop", {63'h0, req}, 64'h0);
      return;
    end
    repeat (lat) @(negedge clk);
    check("wr_data_stable", dout, ed);
    check("wr_addr_stable", addr, a);
    check("wr_req_held", {63'h0, req}, 64'h1);
    if (use_mem) mem[a[12:0]] = dout;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    wr_count++;
    check("wr_gap_low", {63'h0, req}, 64'h0);
  endtask

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic [63:0] first_addrs[3];

  initial begin
    rst = 1'b1; rdy = 1'b0; din = 64'h0;
    seed0 = 16'h1; seed1 = 16'h0; seed2 = 16'h0; seed3 = 16'h0;
    range_v = 64'h1fff;
    vecs[0] = '{rd_data: 64'h41,                   exp_dout: 64'h42,                   lat: 3};
    vecs[1] = '{rd_data: 64'hFFFF_FFFF_FFFF_FFFF,  exp_dout: 64'h0,                    lat: 2};
    vecs[2] = '{rd_data: 64'h0,                    exp_dout: 64'h1,                    lat: 0};
    vecs[3] = '{rd_data: 64'h8000_0000_0000_0000,  exp_dout: 64'h8000_0000_0000_0001,  lat: 1};
    vecs[4] = '{rd_data: 64'hFFFF_FFFF_FFFF_FFFE,  exp_dout: 64'hFFFF_FFFF_FFFF_FFFF,  lat: 4};
    @(negedge clk);

    // Seed 1, range 0x1fff: first request timing and address
    do_reset();
    begin
      int n = 0;
      while (!req && n < 3) begin
        @(negedge clk);
        n++;
      end
      check("first_req_by_cycle3", {63'h0, req}, 64'h1);
      check("first_addr", addr, 64'h0);
    end

    // Table-driven read/increment/write vectors
    for (int i = 0; i < 5; i++) begin
      do_read(vecs[i].lat, 1'b0, vecs[i].rd_data, vecs[i].exp_dout);
      do_write(vecs[i].lat, 1'b0, 1'b0);
    end

    // All-zero seeds fall back to the default seed; full range never yields addr 0
    seed0 = 16'h0;
    range_v = '1;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      do_read($urandom_range(0, 2), 1'b0, v, v + 64'd1);
      check("addr_nonzero", {63'h0, (addr != 64'h0)}, 64'h1);
      do_write($urandom_range(0, 2), 1'b0, 1'b0);
    end
    // Zero range forces every address to 0
    range_v = 64'h0;
    for (int i = 0; i < 10; i++) begin
      do_read(1, 1'b0, 64'h5, 64'h6);
      check("range0_addr", addr, 64'h0);
      do_write(1, 1'b0, 1'b0);
    end

    // Memory model with random latencies
    seed0 = 16'(($urandom_range(1, 65535))); seed1 = 16'($urandom); seed2 = 16'($urandom); seed3 = 16'($urandom);
    range_v = 64'h1fff;
    for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom};
    do_reset();
    begin
      int start = cycles;
      while (cycles - start < 10000) begin
        do_read($urandom_range(0, 5), 1'b1, 64'h0, 64'h0);
        do_write($urandom_range(0, 5), 1'b1, 1'b0);
      end
    end
`ifdef OP_COUNT_EN
    check("op_count", {32'h0, op_count}, {32'h0, wr_count});
`endif

    // Reset asserted while a write is pending: sequence restarts from the seed
    seed0 = 16'h1234; seed1 = 16'h5678; seed2 = 16'h9abc; seed3 = 16'hdef0;
    range_v = '1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_read(1, 1'b0, 64'(i), 64'(i + 1));
      first_addrs[i] = addr;
      do_write(1, 1'b0, (i == 2));
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_read(2, 1'b0, 64'h10, 64'h11);
      check("restart_addr_repeat", addr, first_addrs[i]);
      do_write(0, 1'b0, 1'b0);
    end
`ifdef OP_COUNT_EN
    check("op_count_after_restart", {32'h0, op_count}, 64'd3);
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_rmw_gen.md
Name: sys_rmw_gen

Overview:
- Self-running memory exerciser: generates pseudo-random addresses, reads each location, and writes back the value incremented by INCR.
- Acts as a bus master on a simple req/wr/rdy single-outstanding handshake toward an external memory model or controller.
- The address sequence comes from a seeded 64-bit LFSR, masked by a runtime range input.

Parameters:
- DATA_W, 64, width of din/dout.
- ADDR_W, 64, width of addr, range and the LFSR.
- INCR, 1, value added to read data before write-back.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- addr  out  ADDR_W  transaction address; stable while req=1.
- din  in  DATA_W  read data; valid in the cycle rdy=1 of a read.
- dout  out  DATA_W  write data; stable while req=1 and wr=1.
- req  out  1  transaction request; held until rdy.
- wr  out  1  1=write, 0=read; stable while req=1.
- rdy  in  1  one-cycle completion pulse from the slave.
- seed0..seed3  in  16 each  LFSR seed, concatenated {seed3,seed2,seed1,seed0}.
- range  in  ADDR_W  address mask; addr = lfsr & range.

Behaviour:
- Reset (async, active-high): req=0, wr=0, addr=0, dout=0, lfsr=0, and the FSM goes to SEED.
- FSM states: SEED, GEN, RD, CALC, WR, GAP.
  - SEED: load lfsr from the seed concatenation. If the concatenation is all-zero, load SEED_DFLT=64'h1 instead. Then go to GEN.
  - GEN: addr <= next_lfsr & range; lfsr <= next_lfsr. Then go to RD.
  - RD: req=1, wr=0. Hold until rdy=1 is sampled; on that edge capture din into a data register and go to CALC. req drops the next cycle.
  - CALC: req=0; dout <= captured + INCR, modulo 2^DATA_W, so all-ones wraps to 0. Then go to WR.
  - WR: req=1, wr=1, same addr. Hold until rdy=1, then go to GAP.
  - GAP: req=0 for one cycle, then go to GEN.
- req is therefore low for at least one full cycle between any two transactions. A slave that samples req one cycle after its rdy pulse never sees a stale request.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1, shifting right with feedback from bit 0. It advances exactly once per read/write pair.
- addr, wr and dout do not change while req=1.
- rdy outside RD/WR is ignored. There is no timeout; the FSM waits indefinitely for rdy.
- range and seeds are sampled only where used: seeds in SEED, range in GEN. Changing range mid-transaction has no effect until the next GEN.
- Reset mid-transaction aborts immediately: req=0, and the sequence restarts from SEED after release.

Optional Feature:
- Macro OP_COUNT_EN.
- Defined: adds output op_count[31:0], reset to 0, incremented on each rdy accepted in WR, wrapping at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sys_rmw_pkg holds:
  - state enum (SEED, GEN, RD, CALC, WR, GAP);
  - LFSR_TAPS = 64'hD800_0000_0000_0000;
  - SEED_DFLT = 64'h1.
- One sub-module, lfsr64_galois: combinational next-state function, next = (s>>1) ^ (s[0] ? TAPS : 0).
- The FSM, data register and output registers live in the top module.

Test Plan:
- Reset then release with seeds 1,0,0,0 and range 0x1fff: the first req is a read (wr=0) with addr = (next of 64'h1) & 0x1fff, and req is asserted by the 3rd cycle after release.
- Read handshake: return din=0x0000_0000_0000_0041 with rdy pulsed 3 cycles after req. The next request is a write to the same addr with dout=0x42, and req is low for exactly one cycle between the read and the write.
- Wrap: din=0xFFFF_FFFF_FFFF_FFFF returns dout=0 on the write.
- Seeds all zero: the LFSR uses SEED_DFLT and addr is never stuck at 0 across 100 transactions. With range=0 every addr is 0.
- Run a 8192-entry memory model with random rdy latencies for 10000 cycles: every write equals the model's previous value +1, and addr never exceeds 0x1fff.
- Assert rst while req=1 in WR: req drops asynchronously. After release the address sequence repeats exactly from the first address, and op_count (OP_COUNT_EN) resets to 0.
